muldiv_unit: RTL

- Iterative RV64M multiply/divide engine, issued by the execute stage when the decoder flags `ctrl.is_muldiv`.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W variants (`is_op32`).
- Valid/ready issue handshake; a one-cycle `rvalid` pulse returns the result.
- The pipeline stalls the execute stage while `ready` is low or the result is pending.

---
 rtl/muldiv_if.sv | 35 +++
 rtl/muldiv_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if : issue/result bus between the execute stage and muldiv_unit.
//
//   valid    requester -> unit   issue request (looked at only while ready=1)
//   ready    unit -> requester   unit idle, issue accepted on this edge
//   funct3   requester -> unit   M-extension funct3 (000 MUL .. 111 REMU)
//   is_op32  requester -> unit   W variant
//   op1/op2  requester -> unit   rs1 / rs2 values
//   flush    requester -> unit   abort the in-flight operation
//   rvalid   unit -> requester   one-cycle result strobe
//   result   unit -> requester   result, stable until the next rvalid
// -----------------------------------------------------------------------------
interface muldiv_if #(
   parameter int XLEN = 64
);
   logic            valid;
   logic            ready;
   logic [2:0]      funct3;
   logic            is_op32;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            flush;
   logic            rvalid;
   logic [XLEN-1:0] result;

   modport master (
      output valid, funct3, is_op32, op1, op2, flush,
      input  ready, rvalid, result
   );

   modport slave (
      input  valid, funct3, is_op32, op1, op2, flush,
      output ready, rvalid, result
   );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit : iterative RV64M multiply / divide engine.
//
// Ports:
//   clk  core clock
//   rst  asynchronous reset, active-high
//   bus  muldiv_if.slave (valid/ready issue, funct3, is_op32, op1, op2,
//        flush, rvalid, result)
//
// Multiplies use a radix-2 shift-add over XLEN cycles, divides a restoring
// shift-subtract over XLEN cycles, both on operand magnitudes with the sign
// fixed up on the last step. Divide-by-zero and signed overflow bypass the
// iteration and go straight to FINISH.
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN = 64
) (
   input logic     clk,
   input logic     rst,
   muldiv_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;

   localparam int              CW       = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   // Extend a 32-bit operand to XLEN, signed or unsigned.
   function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
      return {{(XLEN-32){sgn & v[31]}}, v};
   endfunction

   // W variants return the low word sign-extended.
   function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] v, input logic w);
      return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   // ---------------------------------------------------------------- state
   state_t            state_q,  state_d;
   logic [CW-1:0]     cnt_q,    cnt_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              op32_q,   op32_d;
   logic              neg_q,    neg_d;     // product / quotient sign
   logic              rneg_q,   rneg_d;    // remainder sign
   // Mul: {partial product high, multiplier shifting out}.
   // Div: {partial remainder, dividend shifting out / quotient shifting in}.
   logic [2*XLEN-1:0] acc_q,    acc_d;
   logic [XLEN-1:0]   mcand_q,  mcand_d;   // multiplicand or divisor magnitude
   logic [XLEN-1:0]   result_q, result_d;

   // ------------------------------------------------- operand preparation
   logic            in_div, s1_in, s2_in;
   logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, special_res;
   logic            a_neg, b_neg, div_zero, div_ovf;

   assign in_div = bus.funct3[2];
   assign s1_in  = in_div ? ~bus.funct3[0] : (bus.funct3 == 3'b001 || bus.funct3 == 3'b010);
   assign s2_in  = in_div ? ~bus.funct3[0] : (bus.funct3 == 3'b001);

   assign a_ext  = bus.is_op32 ? ext32(bus.op1[31:0], s1_in) : bus.op1;
   assign b_ext  = bus.is_op32 ? ext32(bus.op2[31:0], s2_in) : bus.op2;
   assign a_neg  = s1_in & a_ext[XLEN-1];
   assign b_neg  = s2_in & b_ext[XLEN-1];
   assign a_mag  = a_neg ? -a_ext : a_ext;
   assign b_mag  = b_neg ? -b_ext : b_ext;

   assign div_zero = (b_ext == '0);
   // Overflow is judged at the operative width: a 32-bit MIN / -1 does not
   // look like an overflow once extended to 64 bits.
   assign div_ovf  = s1_in & (bus.is_op32
                     ? (a_ext[31:0] == 32'h8000_0000 && b_ext[31:0] == 32'hFFFF_FFFF)
                     : (a_ext == MOST_NEG && b_ext == '1));

   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = bus.funct3[1] ? a_ext : '1;
      else
         special_res = bus.funct3[1] ? '0 : a_ext;
   end

   // ------------------------------------------------------- multiply step
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, mul_sgn;
   logic [XLEN-1:0]   mul_pick;

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
   assign mul_sgn  = neg_q ? -mul_next : mul_next;
   assign mul_pick = (funct3_q == 3'b000) ? mul_sgn[XLEN-1:0] : mul_sgn[2*XLEN-1:XLEN];

   // -------------------------------------------------------- divide step
   logic [XLEN:0]   div_sh, div_diff;
   logic            div_fits;
   logic [XLEN-1:0] div_r, div_q, quo_fin, rem_fin, div_pick;

   assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_diff = div_sh - {1'b0, mcand_q};
   assign div_fits = ~div_diff[XLEN];
   assign div_r    = div_fits ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
   assign div_q    = {acc_q[XLEN-2:0], div_fits};
   assign quo_fin  = neg_q  ? -div_q : div_q;
   assign rem_fin  = rneg_q ? -div_r : div_r;
   assign div_pick = funct3_q[1] ? rem_fin : quo_fin;

   // ------------------------------------------------ next-state / datapath
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      funct3_d = funct3_q;
      op32_d   = op32_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            // flush beats a simultaneous issue
            if (bus.valid && !bus.flush) begin
               funct3_d = bus.funct3;
               op32_d   = bus.is_op32;
               neg_d    = a_neg ^ b_neg;
               rneg_d   = a_neg;
               cnt_d    = '0;
               if (in_div) begin
                  acc_d   = {{XLEN{1'b0}}, a_mag};
                  mcand_d = b_mag;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, b_mag};
                  mcand_d = a_mag;
               end
               if (in_div && (div_zero || div_ovf)) begin
                  result_d = wfix(special_res, bus.is_op32);
                  state_d  = S_FINISH;
               end else begin
                  state_d  = in_div ? S_DIV : S_MUL;
               end
            end
         end
         S_MUL: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = mul_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  result_d = wfix(mul_pick, op32_q);
                  cnt_d    = '0;
                  state_d  = S_FINISH;
               end
            end
         end
         S_DIV: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = {div_r, div_q};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  result_d = wfix(div_pick, op32_q);
                  cnt_d    = '0;
                  state_d  = S_FINISH;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         funct3_q <= '0;
         op32_q   <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         funct3_q <= funct3_d;
         op32_q   <= op32_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         result_q <= result_d;
      end
   end

   assign bus.ready  = (state_q == S_IDLE);
   // A flush during FINISH suppresses the strobe in that same cycle.
   assign bus.rvalid = (state_q == S_FINISH) && !bus.flush;
   assign bus.result = result_q;

endmodule
